// File: rtl/machina_pkg.sv
// Shared state encoding and fixed-point constants for the machina datapath blocks.
package machina_pkg;

  typedef enum logic [2:0] {
    ARG = 3'd0,
    ACT = 3'd1,
    RES = 3'd2,
    ERR = 3'd3,
    FBK = 3'd4
  } state_t;

  // Q0.8 activation midpoint and full-scale code
  localparam int OFFSET     = 128;
  localparam int FULL_SCALE = 255;

endpackage

// File: rtl/transfer.sv
// Piecewise-linear sigmoid: Q8.8 sum -> clamped Q0.8 activation, plus the backward delta err*slope.
// One operand in flight; res appears 2 cycles after arg ack, every stb holds until acked.
module transfer
  import machina_pkg::*;
#(
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        arg_stb,
  input  logic [15:0] arg_dat,
  output logic        arg_rdy,
  output logic        res_stb,
  output logic [7:0]  res_dat,
  input  logic        res_rdy,
  input  logic        err_stb,
  input  logic [15:0] err_dat,
  output logic        err_rdy,
  output logic        fbk_stb,
  output logic [15:0] fbk_dat,
  input  logic        fbk_rdy
);

  localparam logic [7:0] SLOPE = 8'(1 << (8 - SHIFT));

  state_t             state;
  logic [15:0]        x;
  logic [7:0]         deriv;
  logic signed [16:0] t;
  logic signed [23:0] prod;
  logic               lo;
  logic               hi;

  assign arg_rdy = (state == ARG);
  assign err_rdy = (state == ERR);

  assign t    = ($signed({x[15], x}) >>> SHIFT) + $signed(17'(OFFSET));
  assign lo   = t[16];
  assign hi   = (t > $signed(17'(FULL_SCALE)));
  // Both operands widened to 24 bits so the product is not truncated early
  assign prod = $signed({{8{err_dat[15]}}, err_dat}) * $signed({16'b0, deriv});

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARG;
      x       <= '0;
      deriv   <= '0;
      res_stb <= 1'b0;
      res_dat <= '0;
      fbk_stb <= 1'b0;
      fbk_dat <= '0;
    end else begin
      case (state)
        ARG: if (arg_stb) begin
          x     <= arg_dat;
          state <= ACT;
        end
        ACT: begin
          res_dat <= lo ? 8'd0 : (hi ? 8'(FULL_SCALE) : t[7:0]);
          deriv   <= (lo || hi) ? 8'd0 : SLOPE;
          res_stb <= 1'b1;
          state   <= RES;
        end
        RES: if (res_rdy) begin
          res_stb <= 1'b0;
          state   <= en ? ERR : ARG;
        end
        ERR: if (err_stb) begin
          fbk_dat <= prod[23:8];
          fbk_stb <= 1'b1;
          state   <= FBK;
        end
        FBK: if (fbk_rdy) begin
          fbk_stb <= 1'b0;
          state   <= ARG;
        end
        default: state <= ARG;
      endcase
    end
  end

endmodule

// File: tb/tb_transfer.sv
// Directed-vector bench for transfer with SHIFT=2; all expectations hand-computed.
module tb_transfer;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        arg_stb;
  logic [15:0] arg_dat;
  logic        arg_rdy;
  logic        res_stb;
  logic [7:0]  res_dat;
  logic        res_rdy;
  logic        err_stb;
  logic [15:0] err_dat;
  logic        err_rdy;
  logic        fbk_stb;
  logic [15:0] fbk_dat;
  logic        fbk_rdy;

  int total = 0;
  int bad   = 0;

  transfer #(.SHIFT(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
    .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy),
    .err_stb(err_stb), .err_dat(err_dat), .err_rdy(err_rdy),
    .fbk_stb(fbk_stb), .fbk_dat(fbk_dat), .fbk_rdy(fbk_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one operand; optionally stall res/fbk and inject junk in non-accepting states
  task automatic run(input logic [15:0] a, input logic e, input logic [15:0] er,
                     input logic [7:0] exp_res, input logic [15:0] exp_fbk,
                     input int res_stall, input int fbk_stall);
    int n;
    n = 0;
    while (!arg_rdy && n < 20) begin
      step();
      n++;
    end
    chk("arg_rdy_wait", arg_rdy, 1'b1);
    arg_stb = 1'b1;
    arg_dat = a;
    step();
    arg_stb = 1'b0;
    arg_dat = 16'hDEAD;
    chk("res_stb_act", res_stb, 1'b0);
    err_stb = 1'b1;
    err_dat = 16'h7777;
    step();
    chk("res_stb_lat", res_stb, 1'b1);
    chk("res_dat", res_dat, exp_res);
    for (int i = 0; i < res_stall; i++) begin
      en      = ~e;
      arg_stb = 1'b1;
      step();
      chk("res_hold_stb", res_stb, 1'b1);
      chk("res_hold_dat", res_dat, exp_res);
    end
    arg_stb = 1'b0;
    err_stb = 1'b0;
    en      = e;
    res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    en      = ~e;
    chk("res_drop", res_stb, 1'b0);
    if (e) begin
      chk("err_rdy_on", err_rdy, 1'b1);
      err_stb = 1'b1;
      err_dat = er;
      step();
      err_stb = 1'b0;
      chk("fbk_stb", fbk_stb, 1'b1);
      chk("fbk_dat", fbk_dat, exp_fbk);
      for (int i = 0; i < fbk_stall; i++) begin
        step();
        chk("fbk_hold_stb", fbk_stb, 1'b1);
        chk("fbk_hold_dat", fbk_dat, exp_fbk);
      end
      fbk_rdy = 1'b1;
      step();
      fbk_rdy = 1'b0;
      chk("fbk_drop", fbk_stb, 1'b0);
    end else begin
      chk("err_rdy_off", err_rdy, 1'b0);
    end
    chk("back_to_arg", arg_rdy, 1'b1);
  endtask

  task automatic reset_check(input string tag);
    rst = 1'b1;
    step();
    chk({tag, "_res_stb"}, res_stb, 1'b0);
    chk({tag, "_fbk_stb"}, fbk_stb, 1'b0);
    chk({tag, "_arg_rdy"}, arg_rdy, 1'b1);
    chk({tag, "_res_dat"}, res_dat, 8'h00);
    chk({tag, "_fbk_dat"}, fbk_dat, 16'h0000);
    rst = 1'b0;
    step();
    chk({tag, "_err_rdy"}, err_rdy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; arg_stb = 1'b0; arg_dat = '0; res_rdy = 1'b0;
    err_stb = 1'b0; err_dat = '0; fbk_rdy = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_res_stb", res_stb, 1'b0);
    chk("rst_fbk_stb", fbk_stb, 1'b0);
    chk("rst_res_dat", res_dat, 8'h00);
    step();
    chk("rel_arg_rdy", arg_rdy, 1'b1);
    chk("rel_err_rdy", err_rdy, 1'b0);

    // forward only, then linear region, clamp edges, and a stalled transfer
    run(16'h0000, 1'b0, 16'h0000, 8'h80, 16'h0000, 2, 0);
    run(16'h0100, 1'b1, 16'hFF00, 8'hC0, 16'hFFC0, 0, 0);
    run(16'h01FC, 1'b1, 16'h0100, 8'hFF, 16'h0040, 0, 0);
    run(16'h0200, 1'b1, 16'h0100, 8'hFF, 16'h0000, 0, 0);
    run(16'hFD00, 1'b1, 16'h0100, 8'h00, 16'h0000, 0, 0);
    run(16'hFF00, 1'b1, 16'h0100, 8'h40, 16'h0040, 5, 3);

    // reset while res_stb is pending
    arg_stb = 1'b1; arg_dat = 16'h0100;
    step();
    arg_stb = 1'b0;
    step();
    chk("pre_rst_res_stb", res_stb, 1'b1);
    reset_check("rst_res");

    // reset while fbk_stb is pending
    arg_stb = 1'b1; arg_dat = 16'h0100;
    step();
    arg_stb = 1'b0;
    step();
    en = 1'b1; res_rdy = 1'b1;
    step();
    res_rdy = 1'b0;
    err_stb = 1'b1; err_dat = 16'h0100;
    step();
    err_stb = 1'b0;
    chk("pre_rst_fbk_stb", fbk_stb, 1'b1);
    reset_check("rst_fbk");

    run(16'h0000, 1'b0, 16'h0000, 8'h80, 16'h0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
